// File: rtl/dot_product_pkg.sv
// Shared types and sizing helpers for the dot-product accumulator datapath.
// The beat tag travels beside the data through every pipeline stage.
package dot_product_pkg;

  typedef struct packed {
    logic valid;
    logic last;
    logic is_signed;
  } beat_tag_t;

  localparam beat_tag_t TAG_IDLE = '{valid: 1'b0, last: 1'b0, is_signed: 1'b0};

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Room for a full tree sum plus guard bits for long packets.
  function automatic int acc_width(input int data_width, input int vector_size,
                                   input int acc_guard);
    return 2 * data_width + clog2(vector_size) + acc_guard;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// Registered binary adder tree: one level per clock, widening one bit per level,
// extension chosen per beat by the tag that travels with the data.
module pipelined_adder_tree
  import dot_product_pkg::*;
#(
  parameter int LEAVES = 8,
  parameter int IN_WIDTH = 64,
  localparam int LEVELS = clog2(LEAVES),
  localparam int OUT_WIDTH = IN_WIDTH + LEVELS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LEAVES*IN_WIDTH-1:0] leaves,
  input  beat_tag_t                  tag_in,
  output logic [OUT_WIDTH-1:0]       sum,
  output beat_tag_t                  tag_out
);

  genvar lv, n;
  for (lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int NODES = LEAVES >> (lv + 1);
    localparam int WI = IN_WIDTH + lv;
    localparam int WO = WI + 1;

    logic [2*NODES*WI-1:0] src;
    beat_tag_t             src_tag;
    wire  [NODES*WO-1:0]   sum_d;
    logic [NODES*WO-1:0]   sum_q;
    beat_tag_t             tag_q;

    if (lv == 0) begin : g_src_leaf
      assign src     = leaves;
      assign src_tag = tag_in;
    end else begin : g_src_level
      assign src     = g_lvl[lv-1].sum_q;
      assign src_tag = g_lvl[lv-1].tag_q;
    end

    for (n = 0; n < NODES; n++) begin : g_node
      logic [WI-1:0] lhs, rhs;
      assign lhs = src[(2*n)*WI +: WI];
      assign rhs = src[(2*n+1)*WI +: WI];
      assign sum_d[n*WO +: WO] = {src_tag.is_signed & lhs[WI-1], lhs}
                               + {src_tag.is_signed & rhs[WI-1], rhs};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        tag_q <= TAG_IDLE;
      end else begin
        sum_q <= sum_d;
        tag_q <= src_tag;
      end
    end
  end

  assign sum     = g_lvl[LEVELS-1].sum_q;
  assign tag_out = g_lvl[LEVELS-1].tag_q;

endmodule

// File: rtl/dot_product_accumulator.sv
// Pipelined masked dot product with per-packet accumulation and overflow flag.
// Build option DOT_PRODUCT_SAT_EN saturates dataOut on overflow instead of wrapping.
module dot_product_accumulator
  import dot_product_pkg::*;
#(
  parameter int VECTOR_SIZE = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_GUARD = 8
) (
  input  logic                            clkIn,
  input  logic                            rstIn,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataAIn,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataBIn,
  input  logic [VECTOR_SIZE-1:0]          validIn,
  input  logic                            lastIn,
  input  logic                            signedIn,
  output logic [DATA_WIDTH-1:0]           dataOut,
  output logic                            validOut,
  output logic                            overflowOut
);

  localparam int LEVELS = clog2(VECTOR_SIZE);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + LEVELS;
  localparam int ACC_W  = acc_width(DATA_WIDTH, VECTOR_SIZE, ACC_GUARD);

  // Handshake: there is no ready. Every cycle with any validIn lane or lastIn is a
  // beat and is accepted; validOut is a one-cycle strobe per closed packet.
  wire  [VECTOR_SIZE*PROD_W-1:0] prod_d;
  logic [VECTOR_SIZE*PROD_W-1:0] prod_q;
  beat_tag_t                     tag_d, tag_q, tree_tag;
  logic [SUM_W-1:0]              tree_sum;

  genvar i;
  for (i = 0; i < VECTOR_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a, b;
    logic [PROD_W-1:0]     a_ext, b_ext;
    assign a = dataAIn[i*DATA_WIDTH +: DATA_WIDTH];
    assign b = dataBIn[i*DATA_WIDTH +: DATA_WIDTH];
    assign a_ext = {{DATA_WIDTH{signedIn & a[DATA_WIDTH-1]}}, a};
    assign b_ext = {{DATA_WIDTH{signedIn & b[DATA_WIDTH-1]}}, b};
    // Low 2*DATA_WIDTH bits of the extended product are exact in both modes.
    assign prod_d[i*PROD_W +: PROD_W] = validIn[i] ? a_ext * b_ext : '0;
  end

  assign tag_d = '{valid: (|validIn) | lastIn, last: lastIn, is_signed: signedIn};

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      prod_q <= '0;
      tag_q  <= TAG_IDLE;
    end else begin
      prod_q <= prod_d;
      tag_q  <= tag_d;
    end
  end

  pipelined_adder_tree #(
    .LEAVES   (VECTOR_SIZE),
    .IN_WIDTH (PROD_W)
  ) u_tree (
    .clk     (clkIn),
    .rst     (rstIn),
    .leaves  (prod_q),
    .tag_in  (tag_q),
    .sum     (tree_sum),
    .tag_out (tree_tag)
  );

  logic [ACC_W-1:0]      acc_q, sum_ext, total;
  logic                  pkt_signed_q, pkt_signed, ovf;
  logic [DATA_WIDTH-1:0] result;

  always_comb begin
    sum_ext = tree_tag.is_signed ? ACC_W'($signed(tree_sum)) : ACC_W'(tree_sum);
    total = acc_q + sum_ext;
    pkt_signed = pkt_signed_q | tree_tag.is_signed;
    if (pkt_signed) begin
      ovf = !((&total[ACC_W-1:DATA_WIDTH-1]) || !(|total[ACC_W-1:DATA_WIDTH-1]));
    end else begin
      ovf = |total[ACC_W-1:DATA_WIDTH];
    end
    result = total[DATA_WIDTH-1:0];
`ifdef DOT_PRODUCT_SAT_EN
    if (ovf) begin
      if (!pkt_signed) result = '1;
      else if (total[ACC_W-1]) result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      acc_q        <= '0;
      pkt_signed_q <= 1'b0;
      dataOut      <= '0;
      validOut     <= 1'b0;
      overflowOut  <= 1'b0;
    end else begin
      validOut    <= tree_tag.valid & tree_tag.last;
      overflowOut <= tree_tag.valid & tree_tag.last & ovf;
      if (tree_tag.valid) begin
        if (tree_tag.last) begin
          acc_q        <= '0;
          pkt_signed_q <= 1'b0;
          dataOut      <= result;
        end else begin
          acc_q        <= total;
          pkt_signed_q <= pkt_signed;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: directed cases plus random packets against an
// exact-arithmetic packet model; honours DOT_PRODUCT_SAT_EN when defined.
module tb_dot_product_accumulator;

  localparam int VS = 8;
  localparam int DW = 32;
  localparam int L  = 3;
  localparam int EW = 32 + 1 + DW;
  localparam logic signed [127:0] MAXS = 128'sd2147483647;
  localparam logic signed [127:0] MINS = -128'sd2147483648;
  localparam logic signed [127:0] MAXU = 128'sd4294967295;

  logic clk = 1'b0;
  logic rst;
  logic [VS*DW-1:0] data_a, data_b;
  logic [VS-1:0] valid_in;
  logic last_in, signed_in;
  logic [DW-1:0] data_out;
  logic valid_out, overflow_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic signed [127:0] mdl_acc;
  logic mdl_sgn;

  dot_product_accumulator #(
    .VECTOR_SIZE (VS),
    .DATA_WIDTH  (DW),
    .ACC_GUARD   (8)
  ) dut (
    .clkIn       (clk),
    .rstIn       (rst),
    .dataAIn     (data_a),
    .dataBIn     (data_b),
    .validIn     (valid_in),
    .lastIn      (last_in),
    .signedIn    (signed_in),
    .dataOut     (data_out),
    .validOut    (valid_out),
    .overflowOut (overflow_out)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: each closed packet is due on an exact edge; every other cycle is quiet
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      chk("rst_valid", 64'(valid_out), 64'(0));
      chk("rst_data", 64'(data_out), 64'(0));
      chk("rst_ovf", 64'(overflow_out), 64'(0));
    end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
      e = exp_q.pop_front();
      chk("res_valid", 64'(valid_out), 64'(1));
      chk("res_data", 64'(data_out), 64'(e[DW-1:0]));
      chk("res_ovf", 64'(overflow_out), 64'(e[DW]));
    end else begin
      chk("quiet_valid", 64'(valid_out), 64'(0));
    end
  end

  // driver: presents one cycle of inputs and folds a beat into the packet model
  task automatic beat(input logic [VS*DW-1:0] a, input logic [VS*DW-1:0] b,
                      input logic [VS-1:0] v, input logic last, input logic sgn);
    logic signed [127:0] av, bv;
    logic [DW-1:0] d;
    logic o;
    data_a = a; data_b = b; valid_in = v; last_in = last; signed_in = sgn;
    if ((|v) || last) begin
      mdl_sgn = mdl_sgn | sgn;
      for (int k = 0; k < VS; k++) begin
        if (v[k]) begin
          av = sgn ? 128'($signed(a[k*DW +: DW])) : 128'(a[k*DW +: DW]);
          bv = sgn ? 128'($signed(b[k*DW +: DW])) : 128'(b[k*DW +: DW]);
          mdl_acc = mdl_acc + av * bv;
        end
      end
      if (last) begin
        if (mdl_sgn) o = (mdl_acc > MAXS) || (mdl_acc < MINS);
        else o = mdl_acc > MAXU;
        d = mdl_acc[DW-1:0];
`ifdef DOT_PRODUCT_SAT_EN
        if (o) d = !mdl_sgn ? 32'hffff_ffff : (mdl_acc < 0 ? 32'h8000_0000 : 32'h7fff_ffff);
`endif
        exp_q.push_back({32'(cyc + L + 2), o, d});
        mdl_acc = '0;
        mdl_sgn = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat('0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [VS*DW-1:0] a_v, b_v;
    logic [DW-1:0] sat_exp;
    mdl_acc = '0; mdl_sgn = 1'b0;
    data_a = '0; data_b = '0; valid_in = '0; last_in = 1'b0; signed_in = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 64'(data_out), 64'(0));
    chk("reset_valid", 64'(valid_out), 64'(0));
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // lanes 1..8 times 1 -> 36
    for (int k = 0; k < VS; k++) begin
      a_v[k*DW +: DW] = DW'(k + 1);
      b_v[k*DW +: DW] = 32'd1;
    end
    beat(a_v, b_v, 8'hff, 1'b1, 1'b0);
    idle(7);
    chk("sum36_hold", 64'(data_out), 64'(36));

    // two-beat packet -> 96, then two single-beat packets back to back -> 48, 48
    for (int k = 0; k < VS; k++) begin
      a_v[k*DW +: DW] = 32'd2;
      b_v[k*DW +: DW] = 32'd3;
    end
    beat(a_v, b_v, 8'hff, 1'b0, 1'b0);
    beat(a_v, b_v, 8'hff, 1'b1, 1'b0);
    idle(7);
    chk("sum96_hold", 64'(data_out), 64'(96));
    beat(a_v, b_v, 8'hff, 1'b1, 1'b0);
    beat(a_v, b_v, 8'hff, 1'b1, 1'b0);
    idle(7);
    chk("sum48_hold", 64'(data_out), 64'(48));

    // partial mask -> 10; empty last beat -> 0
    for (int k = 0; k < VS; k++) begin
      a_v[k*DW +: DW] = DW'(k + 1);
      b_v[k*DW +: DW] = 32'd1;
    end
    beat(a_v, b_v, 8'h0f, 1'b1, 1'b0);
    idle(7);
    chk("mask10_hold", 64'(data_out), 64'(10));
    beat(a_v, b_v, 8'h00, 1'b1, 1'b0);
    idle(7);
    chk("empty_hold", 64'(data_out), 64'(0));

    // signed -2 * 3 over 8 lanes -> -48
    for (int k = 0; k < VS; k++) begin
      a_v[k*DW +: DW] = 32'hffff_fffe;
      b_v[k*DW +: DW] = 32'd3;
    end
    beat(a_v, b_v, 8'hff, 1'b1, 1'b1);
    idle(7);
    chk("neg48_hold", 64'(data_out), 64'(32'hffff_ffd0));

    // signed overflow on lane 0
    a_v[0 +: DW] = 32'h7fff_ffff;
    b_v[0 +: DW] = 32'd2;
    beat(a_v, b_v, 8'h01, 1'b1, 1'b1);
    idle(7);
`ifdef DOT_PRODUCT_SAT_EN
    sat_exp = 32'h7fff_ffff;
`else
    sat_exp = 32'hffff_fffe;
`endif
    chk("ovf_hold", 64'(data_out), 64'(sat_exp));

    // reset mid-packet discards the partial accumulation
    for (int k = 0; k < VS; k++) begin
      a_v[k*DW +: DW] = 32'd5;
      b_v[k*DW +: DW] = 32'd7;
    end
    beat(a_v, b_v, 8'hff, 1'b0, 1'b0);
    beat(a_v, b_v, 8'hff, 1'b0, 1'b0);
    beat(a_v, b_v, 8'hff, 1'b0, 1'b0);
    data_a = '0; data_b = '0; valid_in = '0; last_in = 1'b0; signed_in = 1'b0;
    #2 rst = 1'b1;
    mdl_acc = '0; mdl_sgn = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_data", 64'(data_out), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < VS; k++) begin
      a_v[k*DW +: DW] = 32'd1;
      b_v[k*DW +: DW] = 32'd1;
    end
    beat(a_v, b_v, 8'hff, 1'b1, 1'b0);
    idle(7);
    chk("post_rst_hold", 64'(data_out), 64'(8));

    // random packets, mixed signedness, masks and gaps
    for (int it = 0; it < 80; it++) begin
      for (int k = 0; k < VS; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          a_v[k*DW +: DW] = $urandom;
          b_v[k*DW +: DW] = $urandom;
        end else begin
          a_v[k*DW +: DW] = 32'($urandom_range(0, 40)) - 32'd20;
          b_v[k*DW +: DW] = 32'($urandom_range(0, 40)) - 32'd20;
        end
      end
      beat(a_v, b_v, 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    beat(a_v, b_v, 8'hff, 1'b1, 1'b1);

    idle(10);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
